gene_pair_fetch: RTL and testbench
==================================

Name: gene_pair_fetch

Overview:
- Upstream feeder for the crossover/mutation PE.
- On a start request it walks two parent genomes, selected by population index, through a single-read-port population memory.
- For each word index it presents the matching 32-bit word pair on parent_gene0/parent_gene1 with a valid/ready handshake.
- gene_last marks the final word pair; one FSM sequences address generation, capture and output hold.

Parameters:
- GENE_W, 32, width of one genome word (4 packed 8-bit genes)
- GENOME_WORDS, 16, words per genome; power of two, >=2
- POP_SIZE, 64, genomes in population memory; power of two
- IDX_W, $clog2(POP_SIZE), parent index width
- ADDR_W, $clog2(POP_SIZE*GENOME_WORDS), memory word address width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- start  in  1  request; sampled only in IDLE
- parent0_idx  in  IDX_W  genome index of parent 0; sampled with start
- parent1_idx  in  IDX_W  genome index of parent 1; sampled with start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the final handshake
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  ADDR_W  idx*GENOME_WORDS + word
- mem_rd_data  in  GENE_W  read data, valid exactly 1 cycle after mem_rd_en
- parent_gene0  out  GENE_W  parent-0 word, registered
- parent_gene1  out  GENE_W  parent-1 word, registered
- gene_valid  out  1  word pair valid
- gene_ready  in  1  consumer accepts pair
- gene_last  out  1  qualifies final pair (word GENOME_WORDS-1)

Behaviour:
- Reset (rst==0 at an edge): state IDLE; all outputs 0; word counter 0; applies mid-operation and aborts any transfer without done. First start after release behaves normally.
- States: IDLE, RD0, RD1, CAP, OUT, FIN.
- IDLE: start==1 latches both indices, word=0, goes to RD0. start while not IDLE is ignored.
- RD0: mem_rd_en=1, addr = p0*GENOME_WORDS + word; goes to RD1.
- RD1: captures mem_rd_data into the p0 holding register; mem_rd_en=1, addr = p1*GENOME_WORDS + word; goes to CAP.
- CAP: captures mem_rd_data into the p1 holding register; goes to OUT.
- OUT: gene_valid=1; gene_last=(word==GENOME_WORDS-1).
  - parent_gene0/1, gene_last and gene_valid stay stable while gene_ready==0.
  - On gene_valid&&gene_ready: if last, go to FIN; else word+1 and go to RD0.
- FIN: done=1 and busy=0 for one cycle; outputs cleared; goes to IDLE. A new start is accepted in the next IDLE cycle.
- Latency: start sampled at edge E0 gives RD0 in cycle 1 and gene_valid first high in cycle 4. Steady state is at most one pair per 4 cycles with gene_ready tied high.
- mem_rd_en is 0 in every state other than RD0/RD1.
- Address arithmetic is unsigned; the product is ADDR_W bits with no overflow because of the power-of-two sizing.
- parent0_idx==parent1_idx is legal by default: the same words appear on both outputs.
- gene_valid is never high in the same cycle as done.

Optional Feature:
- Macro GENE_PAIR_SELF_MATE_CHECK_EN.
- When defined: extra output port self_mate_err (1 bit, reset 0).
  - A start with parent0_idx==parent1_idx is rejected: self_mate_err pulses 1 cycle, state stays IDLE, busy stays 0, no memory read, no done.
- When undefined: no port; equal indices are fetched normally.

Decomposition:
- Shared package ga_pkg:
  - GENE_W and GENE_BYTE_W=8
  - FSM state enum (IDLE,RD0,RD1,CAP,OUT,FIN)
  - function gene_addr(idx, word) returning ADDR_W
- No sub-module; one FSM plus datapath registers in a single module.

Test Plan:
(Memory model: mem[a]=32'hA000_0000|a, 1-cycle read latency; default parameters.)
- Basic: start, p0=3, p1=5, gene_ready=1 → word0 pair 0xA0000030/0xA0000050 with gene_valid in cycle 4; 16 pairs total; last pair 0xA000003F/0xA000005F with gene_last=1; done one cycle later.
- Backpressure: gene_ready=0 for 7 cycles on word 2 → pair 0xA0000032/0xA0000052 held stable for all 7 cycles; no mem_rd_en during the hold; the sequence then resumes.
- Start while busy: second start (p0=9, p1=1) at word 4 → ignored; only p0=3/p1=5 addresses appear; a single done.
- Reset mid-operation: rst=0 during word 7 CAP → next cycle all outputs 0, state IDLE. A new start with p0=0, p1=63 → first pair 0xA0000000/0xA00003F0.
- Boundary indices: p0=63, p1=63, macro undefined → both outputs 0xA00003F0…0xA00003FF, last word at addr 1023 with no wrap.
- Macro defined: p0=p1=12 → self_mate_err pulse, no mem_rd_en, busy=0. Follow-up start with p0=12, p1=13 proceeds normally.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared geometry, FSM state encoding and address helper for the GA fetch path.
// Default geometry: 32-bit words of four 8-bit genes, 16 words per genome, 64 genomes.
package ga_pkg;

    localparam int GENE_W       = 32;
    localparam int GENE_BYTE_W  = 8;
    localparam int GENOME_WORDS = 16;
    localparam int POP_SIZE     = 64;
    localparam int IDX_W        = $clog2(POP_SIZE);
    localparam int WORD_W       = $clog2(GENOME_WORDS);
    localparam int ADDR_W       = $clog2(POP_SIZE * GENOME_WORDS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        CAP  = 3'd3,
        OUT  = 3'd4,
        FIN  = 3'd5
    } gpf_state_e;

    // Power-of-two sizing keeps idx*GENOME_WORDS+word inside ADDR_W bits.
    function automatic logic [ADDR_W-1:0] gene_addr(input logic [IDX_W-1:0]  idx,
                                                   input logic [WORD_W-1:0] word);
        return ADDR_W'(idx) * ADDR_W'(GENOME_WORDS) + ADDR_W'(word);
    endfunction

endpackage

// File: rtl/gene_pair_fetch.sv
// Parent word-pair fetcher: reads p0 then p1 word per index and presents the pair downstream.
// Latency: start edge -> first gene_valid 4 cycles; at most one pair per 4 cycles.
// Backpressure: pair, gene_last and gene_valid hold in OUT while gene_ready is low; no reads issued.
// Optional: GENE_PAIR_SELF_MATE_CHECK_EN adds self_mate_err and rejects equal parent indices.
module gene_pair_fetch #(
    parameter int GENE_W       = 32,
    parameter int GENOME_WORDS = 16,
    parameter int POP_SIZE     = 64,
    parameter int IDX_W        = $clog2(POP_SIZE),
    parameter int ADDR_W       = $clog2(POP_SIZE * GENOME_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  parent0_idx,
    input  logic [IDX_W-1:0]  parent1_idx,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [GENE_W-1:0] mem_rd_data,
    output logic [GENE_W-1:0] parent_gene0,
    output logic [GENE_W-1:0] parent_gene1,
    output logic              gene_valid,
    input  logic              gene_ready,
`ifdef GENE_PAIR_SELF_MATE_CHECK_EN
    output logic              self_mate_err,
`endif
    output logic              gene_last
);

    import ga_pkg::*;

    localparam int WORD_W = $clog2(GENOME_WORDS);

    gpf_state_e        r_state;
    gpf_state_e        w_state_nxt;
    logic [IDX_W-1:0]  r_p0_idx;
    logic [IDX_W-1:0]  r_p1_idx;
    logic [WORD_W-1:0] r_word;
    logic [GENE_W-1:0] r_gene0;
    logic [GENE_W-1:0] r_gene1;
    logic              w_last_word;
    logic              w_handshake;
    logic              w_self_mate;
    logic              w_start_ok;

`ifdef GENE_PAIR_SELF_MATE_CHECK_EN
    logic r_self_mate_err;
    assign w_self_mate   = start && (parent0_idx == parent1_idx);
    assign self_mate_err = r_self_mate_err;
`else
    assign w_self_mate = 1'b0;
`endif

    assign w_last_word = (r_word == WORD_W'(GENOME_WORDS - 1));
    assign w_handshake = (r_state == OUT) && gene_ready;
    assign w_start_ok  = (r_state == IDLE) && start && !w_self_mate;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        busy        = 1'b0;
        done        = 1'b0;
        gene_valid  = 1'b0;
        gene_last   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = RD0;
                end
            end
            RD0: begin
                busy        = 1'b1;
                mem_rd_en   = 1'b1;
                mem_rd_addr = gene_addr(r_p0_idx, r_word);
                w_state_nxt = RD1;
            end
            RD1: begin
                busy        = 1'b1;
                mem_rd_en   = 1'b1;
                mem_rd_addr = gene_addr(r_p1_idx, r_word);
                w_state_nxt = CAP;
            end
            CAP: begin
                busy        = 1'b1;
                w_state_nxt = OUT;
            end
            OUT: begin
                busy       = 1'b1;
                gene_valid = 1'b1;
                gene_last  = w_last_word;
                if (w_handshake) begin
                    w_state_nxt = w_last_word ? FIN : RD0;
                end
            end
            FIN: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Read data arrives one cycle after the strobe: RD1 sees p0's word, CAP sees p1's.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p0_idx <= '0;
            r_p1_idx <= '0;
            r_word   <= '0;
            r_gene0  <= '0;
            r_gene1  <= '0;
        end else begin
            if (w_start_ok) begin
                r_p0_idx <= parent0_idx;
                r_p1_idx <= parent1_idx;
                r_word   <= '0;
            end
            if (r_state == RD1) begin
                r_gene0 <= mem_rd_data;
            end
            if (r_state == CAP) begin
                r_gene1 <= mem_rd_data;
            end
            if (w_handshake && !w_last_word) begin
                r_word <= r_word + 1'b1;
            end
            if (r_state == FIN) begin
                r_gene0 <= '0;
                r_gene1 <= '0;
                r_word  <= '0;
            end
        end
    end

`ifdef GENE_PAIR_SELF_MATE_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_self_mate_err <= 1'b0;
        end else begin
            r_self_mate_err <= (r_state == IDLE) && w_self_mate;
        end
    end
`endif

    assign parent_gene0 = r_gene0;
    assign parent_gene1 = r_gene1;

endmodule

// File: tb/tb_gene_pair_fetch.sv
// Directed bench for gene_pair_fetch with a 1-cycle-latency memory model and a pair scoreboard.
module tb_gene_pair_fetch;

    localparam int GW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  parent0_idx;
    logic [5:0]  parent1_idx;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [31:0] parent_gene0;
    logic [31:0] parent_gene1;
    logic        gene_valid;
    logic        gene_ready;
    logic        gene_last;
`ifdef GENE_PAIR_SELF_MATE_CHECK_EN
    logic        self_mate_err;
`endif

    typedef struct {
        logic [31:0] g0;
        logic [31:0] g1;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 32'hA000_0000 | 32'(mem_rd_addr);
    end

    gene_pair_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .parent0_idx  (parent0_idx),
        .parent1_idx  (parent1_idx),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .parent_gene0 (parent_gene0),
        .parent_gene1 (parent_gene1),
        .gene_valid   (gene_valid),
        .gene_ready   (gene_ready),
`ifdef GENE_PAIR_SELF_MATE_CHECK_EN
        .self_mate_err(self_mate_err),
`endif
        .gene_last    (gene_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  busy,         0);
        chk({tag, "_done"},  done,         0);
        chk({tag, "_valid"}, gene_valid,   0);
        chk({tag, "_last"},  gene_last,    0);
        chk({tag, "_rden"},  mem_rd_en,    0);
        chk({tag, "_addr"},  mem_rd_addr,  0);
        chk({tag, "_g0"},    parent_gene0, 0);
        chk({tag, "_g1"},    parent_gene1, 0);
`ifdef GENE_PAIR_SELF_MATE_CHECK_EN
        chk({tag, "_sme"},   self_mate_err, 0);
`endif
    endtask

    // Drives start for the next edge and queues the 16 pairs that fetch must yield.
    task automatic start_op(input int p0, input int p1);
        exp_t e;
        start       = 1'b1;
        parent0_idx = 6'(p0);
        parent1_idx = 6'(p1);
        for (int w = 0; w < GW; w++) begin
            e.g0   = 32'hA000_0000 | 32'(p0 * GW + w);
            e.g1   = 32'hA000_0000 | 32'(p1 * GW + w);
            e.last = (w == GW - 1);
            sb.push_back(e);
        end
    endtask

    task automatic run_stream(input string tag, input int hold_word, input int hold_len,
                              input int inj_word, input int base0, input int base1);
        exp_t e;
        int   word     = 0;
        int   held     = 0;
        int   budget   = 0;
        bit   injected = 0;
        while (sb.size() > 0 && budget < 400) begin
            start = 1'b0;
            if (mem_rd_en)
                chk({tag, "_addr_owner"},
                    64'((32'(mem_rd_addr) / GW == base0) || (32'(mem_rd_addr) / GW == base1)), 1);
            chk({tag, "_no_early_done"}, done, 0);
            if (gene_valid) begin
                if (word == inj_word && !injected) begin
                    start       = 1'b1;
                    parent0_idx = 6'd9;
                    parent1_idx = 6'd1;
                    injected    = 1;
                end
                if (word == hold_word && held < hold_len) begin
                    gene_ready = 1'b0;
                    e = sb[0];
                    chk({tag, "_hold_g0"},   parent_gene0, e.g0);
                    chk({tag, "_hold_g1"},   parent_gene1, e.g1);
                    chk({tag, "_hold_rden"}, mem_rd_en,    0);
                    held++;
                end else begin
                    gene_ready = 1'b1;
                    e = sb.pop_front();
                    chk({tag, "_g0"},   parent_gene0, e.g0);
                    chk({tag, "_g1"},   parent_gene1, e.g1);
                    chk({tag, "_last"}, gene_last,    e.last);
                    word++;
                end
            end
            step();
            budget++;
        end
        if (budget >= 400) begin
            chk({tag, "_timeout"}, 0, 1);
            sb.delete();
        end
        chk({tag, "_done"},       done,       1);
        chk({tag, "_done_valid"}, gene_valid, 0);
        chk({tag, "_done_busy"},  busy,       0);
        step();
        chk({tag, "_done_pulse"}, done,         0);
        chk({tag, "_clr_g0"},     parent_gene0, 0);
        chk({tag, "_clr_g1"},     parent_gene1, 0);
    endtask

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        parent0_idx = '0;
        parent1_idx = '0;
        gene_ready  = 1'b1;
        repeat (3) step();
        chk_idle("reset");
        rst = 1'b1;
        step();
        chk_idle("post_reset");

        // Basic fetch with latency checks on the first word.
        start_op(3, 5);
        step();
        start = 1'b0;
        chk("basic_c1_busy", busy,        1);
        chk("basic_c1_rden", mem_rd_en,   1);
        chk("basic_c1_addr", mem_rd_addr, 10'h030);
        step();
        chk("basic_c2_rden", mem_rd_en,   1);
        chk("basic_c2_addr", mem_rd_addr, 10'h050);
        step();
        chk("basic_c3_rden",  mem_rd_en,  0);
        chk("basic_c3_valid", gene_valid, 0);
        step();
        chk("basic_c4_valid", gene_valid, 1);
        run_stream("basic", -1, 0, -1, 3, 5);

        // Backpressure on word 2 plus an ignored start at word 4.
        start_op(3, 5);
        step();
        start = 1'b0;
        run_stream("bp", 2, 7, 4, 3, 5);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ignored_busy", busy,      0);
            chk("bp_ignored_rden", mem_rd_en, 0);
            step();
        end

        // Reset asserted during word 7 CAP.
        start_op(3, 5);
        sb.delete();
        step();
        start = 1'b0;
        repeat (29) step();
        chk("rst_w7_rd1_addr", mem_rd_addr, 10'h057);
        step();
        chk("rst_w7_cap_busy", busy,      1);
        chk("rst_w7_cap_rden", mem_rd_en, 0);
        rst = 1'b0;
        step();
        chk_idle("midrst");
        rst = 1'b1;
        step();
        chk_idle("midrst_release");
        start_op(0, 63);
        step();
        start = 1'b0;
        run_stream("after_rst", -1, 0, -1, 0, 63);

`ifndef GENE_PAIR_SELF_MATE_CHECK_EN
        start_op(63, 63);
        step();
        start = 1'b0;
        chk("edge_c1_addr", mem_rd_addr, 10'h3F0);
        run_stream("edge_idx", -1, 0, -1, 63, 63);
`else
        start       = 1'b1;
        parent0_idx = 6'd12;
        parent1_idx = 6'd12;
        step();
        start = 1'b0;
        chk("sme_pulse", self_mate_err, 1);
        chk("sme_busy",  busy,          0);
        chk("sme_rden",  mem_rd_en,     0);
        step();
        chk("sme_pulse_end", self_mate_err, 0);
        chk("sme_busy2",     busy,          0);
        chk("sme_rden2",     mem_rd_en,     0);
        chk("sme_done",      done,          0);
        start_op(12, 13);
        step();
        start = 1'b0;
        chk("sme_follow_addr", mem_rd_addr, 10'h0C0);
        run_stream("sme_follow", -1, 0, -1, 12, 13);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
